// File: rtl/regfile_ctrl.sv
// Write-back and hazard controller for the integer register file: busy-bit scoreboard,
// RAW/WAW issue stall and round-robin EXU/LSU arbitration onto the single write port.
module regfile_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             issue_valid,
  input  logic [4:0]       issue_rs1,
  input  logic [4:0]       issue_rs2,
  input  logic [4:0]       issue_rd,
  input  logic             issue_rd_wen,
  output logic             issue_ready,

  input  logic             exu_valid,
  input  logic [4:0]       exu_rd,
  input  logic [WIDTH-1:0] exu_data,
  output logic             exu_ready,

  input  logic             lsu_valid,
  input  logic [4:0]       lsu_rd,
  input  logic [WIDTH-1:0] lsu_data,
  output logic             lsu_ready,

  output logic             rf_wen,
  output logic [4:0]       rf_rd_addr,
  output logic [WIDTH-1:0] rf_rd_data
);

  logic [31:0] busy_q, busy_d;
  logic        last_grant_q;  // 0: EXU won last, 1: LSU won last
  logic        grant_exu;
  logic        grant_lsu;
  logic        issue_fire;

  // Hazard check; busy_q[0] is never set, so x0 cannot stall issue.
  always_comb begin
    issue_ready = !(busy_q[issue_rs1] | busy_q[issue_rs2] | (issue_rd_wen & busy_q[issue_rd]));
    issue_fire  = issue_valid & issue_ready;
  end

  // Round-robin: on contention the unit that did not win last time gets the port.
  always_comb begin
    grant_exu = exu_valid & (!lsu_valid | last_grant_q);
    grant_lsu = lsu_valid & (!exu_valid | !last_grant_q);
    exu_ready = grant_exu;
    lsu_ready = grant_lsu;
  end

  // Clear applied before set so a forced same-bit collision resolves to set.
  always_comb begin
    busy_d = busy_q;
    if (rf_wen) begin
      busy_d[rf_rd_addr] = 1'b0;
    end
    if (issue_fire && issue_rd_wen && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      last_grant_q <= 1'b1;
      rf_wen       <= 1'b0;
      rf_rd_addr   <= '0;
      rf_rd_data   <= '0;
    end else begin
      busy_q <= busy_d;
      if (grant_exu) begin
        last_grant_q <= 1'b0;
        rf_wen       <= (exu_rd != 5'd0);
        rf_rd_addr   <= exu_rd;
        rf_rd_data   <= exu_data;
      end else if (grant_lsu) begin
        last_grant_q <= 1'b1;
        rf_wen       <= (lsu_rd != 5'd0);
        rf_rd_addr   <= lsu_rd;
        rf_rd_data   <= lsu_data;
      end else begin
        rf_wen <= 1'b0;
      end
    end
  end

  grant_onehot_a: assert property (@(posedge clk) disable iff (rst) !(exu_ready && lsu_ready));

endmodule

// File: tb/tb_regfile_ctrl.sv
// Scenario bench for regfile_ctrl: write-backs are queued when granted and matched on rf_wen.
module tb_regfile_ctrl;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid, issue_rd_wen, issue_ready;
  logic [4:0]       issue_rs1, issue_rs2, issue_rd;
  logic             exu_valid, exu_ready, lsu_valid, lsu_ready;
  logic [4:0]       exu_rd, lsu_rd;
  logic [WIDTH-1:0] exu_data, lsu_data;
  logic             rf_wen;
  logic [4:0]       rf_rd_addr;
  logic [WIDTH-1:0] rf_rd_data;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0]       addr;
    logic [WIDTH-1:0] data;
  } wb_t;

  wb_t exp_q[$];
  wb_t mon_e;

  always #5 clk = ~clk;

  regfile_ctrl #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .issue_rd     (issue_rd),
    .issue_rd_wen (issue_rd_wen),
    .issue_ready  (issue_ready),
    .exu_valid    (exu_valid),
    .exu_rd       (exu_rd),
    .exu_data     (exu_data),
    .exu_ready    (exu_ready),
    .lsu_valid    (lsu_valid),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .lsu_ready    (lsu_ready),
    .rf_wen       (rf_wen),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_data   (rf_rd_data)
  );

  // Scoreboard: every register file write must match the oldest expected write-back.
  always @(negedge clk) begin
    if (rf_wen === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected got addr=%0d data=%h required no write", rf_rd_addr,
                 rf_rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_rd_addr !== mon_e.addr || rf_rd_data !== mon_e.data) begin
          failures++;
          $display("FAIL wb_data got addr=%0d data=%h required addr=%0d data=%h", rf_rd_addr,
                   rf_rd_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid  = 1'b0;
    issue_rs1    = 5'd0;
    issue_rs2    = 5'd0;
    issue_rd     = 5'd0;
    issue_rd_wen = 1'b0;
    exu_valid    = 1'b0;
    exu_rd       = 5'd0;
    exu_data     = '0;
    lsu_valid    = 1'b0;
    lsu_rd       = 5'd0;
    lsu_data     = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) next_cycle();
    rst = 1'b0;
    checks++;
    if (rf_wen !== 1'b0 || rf_rd_addr !== 5'd0 || rf_rd_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_wb got wen=%b addr=%0d data=%h required 0/0/0", rf_wen, rf_rd_addr,
               rf_rd_data);
    end
    issue_rs1 = 5'd5; issue_rs2 = 5'd9; issue_rd = 5'd7; issue_rd_wen = 1'b1;
    #1;
    checks++;
    if (issue_ready !== 1'b1 || exu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got issue=%b exu=%b lsu=%b required 1/0/0", issue_ready,
               exu_ready, lsu_ready);
    end
    idle_inputs();
  endtask

  task automatic test_contention();
    int  e_idx = 0;
    int  l_idx = 0;
    logic exp_exu;
    for (int i = 0; i < 4; i++) begin
      exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'hE000_0000 + e_idx;
      lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hA000_0000 + l_idx;
      #1;
      exp_exu = (i % 2 == 0);
      checks++;
      if (exu_ready !== exp_exu || lsu_ready !== !exp_exu) begin
        failures++;
        $display("FAIL rr_grant[%0d] got exu=%b lsu=%b required exu=%b lsu=%b", i, exu_ready,
                 lsu_ready, exp_exu, !exp_exu);
      end
      if (exp_exu) begin
        exp_q.push_back('{addr: 5'd3, data: exu_data});
        e_idx++;
      end else begin
        exp_q.push_back('{addr: 5'd4, data: lsu_data});
        l_idx++;
      end
      next_cycle();
      checks++;
      if (rf_wen !== 1'b1) begin
        failures++;
        $display("FAIL rr_wen[%0d] got %b required 1", i, rf_wen);
      end
    end
    idle_inputs();
    next_cycle();
    checks++;
    if (rf_wen !== 1'b0) begin
      failures++;
      $display("FAIL rr_idle_wen got %b required 0", rf_wen);
    end
  endtask

  task automatic test_raw();
    issue_valid = 1'b1; issue_rd = 5'd5; issue_rs1 = 5'd1; issue_rs2 = 5'd2; issue_rd_wen = 1'b1;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL raw_producer_ready got %b required 1", issue_ready);
    end
    next_cycle();
    issue_rs1 = 5'd5; issue_rs2 = 5'd0; issue_rd = 5'd6;
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      failures++;
      $display("FAIL raw_stall got %b required 0", issue_ready);
    end
    next_cycle();
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (exu_ready !== 1'b1 || issue_ready !== 1'b0) begin
      failures++;
      $display("FAIL raw_grant got exu=%b issue=%b required 1/0", exu_ready, issue_ready);
    end
    exp_q.push_back('{addr: 5'd5, data: 32'hDEAD_BEEF});
    next_cycle();
    exu_valid = 1'b0;
    #1;
    checks++;
    if (rf_wen !== 1'b1 || rf_rd_addr !== 5'd5 || rf_rd_data !== 32'hDEAD_BEEF ||
        issue_ready !== 1'b0) begin
      failures++;
      $display("FAIL raw_write got wen=%b addr=%0d data=%h issue=%b required 1/5/deadbeef/0",
               rf_wen, rf_rd_addr, rf_rd_data, issue_ready);
    end
    next_cycle();
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL raw_release got %b required 1", issue_ready);
    end
    next_cycle();
    // The consumer fired above with rd=x6, so x6 must now be busy.
    issue_valid = 1'b0; issue_rs1 = 5'd6; issue_rd_wen = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h0000_0606;
    #1;
    checks++;
    if (issue_ready !== 1'b0 || lsu_ready !== 1'b1) begin
      failures++;
      $display("FAIL raw_consumer_busy got issue=%b lsu=%b required 0/1", issue_ready, lsu_ready);
    end
    exp_q.push_back('{addr: 5'd6, data: 32'h0000_0606});
    next_cycle();
    lsu_valid = 1'b0;
    next_cycle();
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL raw_consumer_clear got %b required 1", issue_ready);
    end
    idle_inputs();
  endtask

  task automatic test_x0();
    issue_valid = 1'b1; issue_rd = 5'd0; issue_rd_wen = 1'b1;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL x0_issue got %b required 1", issue_ready);
    end
    next_cycle();
    exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'h0000_0055;
    #1;
    checks++;
    if (issue_ready !== 1'b1 || exu_ready !== 1'b1) begin
      failures++;
      $display("FAIL x0_no_busy got issue=%b exu=%b required 1/1", issue_ready, exu_ready);
    end
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (rf_wen !== 1'b0 || rf_rd_addr !== 5'd0 || rf_rd_data !== 32'h55 ||
        issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL x0_write got wen=%b addr=%0d data=%h issue=%b required 0/0/55/1", rf_wen,
               rf_rd_addr, rf_rd_data, issue_ready);
    end
  endtask

  task automatic test_waw();
    issue_valid = 1'b1; issue_rd = 5'd7; issue_rd_wen = 1'b1;
    next_cycle();
    issue_valid = 1'b0;
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      failures++;
      $display("FAIL waw_stall got %b required 0", issue_ready);
    end
    issue_rd_wen = 1'b0;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL waw_no_wen got %b required 1", issue_ready);
    end
    issue_rd_wen = 1'b1;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h7777_0007;
    exp_q.push_back('{addr: 5'd7, data: 32'h7777_0007});
    next_cycle();
    lsu_valid = 1'b0;
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      failures++;
      $display("FAIL waw_write_cycle got %b required 0", issue_ready);
    end
    next_cycle();
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL waw_release got %b required 1", issue_ready);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      exu_valid = 1'b1; exu_rd = 5'd11 + 5'(i); exu_data = 32'hB2B0_0000 + i;
      exp_q.push_back('{addr: 5'd11 + 5'(i), data: 32'hB2B0_0000 + i});
      next_cycle();
      checks++;
      if (rf_wen !== 1'b1) begin
        failures++;
        $display("FAIL b2b_wen[%0d] got %b required 1", i, rf_wen);
      end
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    issue_valid = 1'b1; issue_rd = 5'd9; issue_rd_wen = 1'b1;
    next_cycle();
    issue_valid = 1'b0; issue_rd_wen = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd9;
    exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'h0000_0033;
    exp_q.push_back('{addr: 5'd3, data: 32'h0000_0033});
    next_cycle();
    exu_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (rf_wen !== 1'b1 || issue_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_pre got wen=%b issue=%b required 1/0", rf_wen, issue_ready);
    end
    next_cycle();
    rst = 1'b0;
    // Contention straight after reset must go to EXU first.
    exu_valid = 1'b1; exu_rd = 5'd20; exu_data = 32'h2020_2020;
    lsu_valid = 1'b1; lsu_rd = 5'd21; lsu_data = 32'h2121_2121;
    #1;
    checks++;
    if (rf_wen !== 1'b0 || rf_rd_addr !== 5'd0 || rf_rd_data !== 32'h0 ||
        issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_post got wen=%b addr=%0d data=%h issue=%b required 0/0/0/1", rf_wen,
               rf_rd_addr, rf_rd_data, issue_ready);
    end
    checks++;
    if (exu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_rr got exu=%b lsu=%b required 1/0", exu_ready, lsu_ready);
    end
    exp_q.push_back('{addr: 5'd20, data: 32'h2020_2020});
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_contention();
    test_raw();
    test_x0();
    test_waw();
    test_back_to_back();
    test_reset_mid();
    repeat (3) next_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL wb_drain got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
